// File: rtl/data_mem_responder_pkg.sv
// Shared types and byte-lane helpers for the MEM-stage data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_B0      = 4'b0001;
  localparam logic [3:0] BE_B1      = 4'b0010;
  localparam logic [3:0] BE_B2      = 4'b0100;
  localparam logic [3:0] BE_B3      = 4'b1000;

  // Only naturally aligned word, halfword and byte patterns are accepted.
  function automatic bit be_legal(input logic [1:0] addrLo, input logic [3:0] be);
    case (be)
      BE_WORD:    return addrLo == 2'b00;
      BE_HALF_LO: return addrLo == 2'b00;
      BE_HALF_HI: return addrLo == 2'b10;
      BE_B0:      return addrLo == 2'b00;
      BE_B1:      return addrLo == 2'b01;
      BE_B2:      return addrLo == 2'b10;
      BE_B3:      return addrLo == 2'b11;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory bus: the pipeline is the master, the responder the slave.
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemDataIn;
  logic [3:0]  ByteEn;
  logic [31:0] MemDataOut;
  logic        MemReady;
  logic        MemError;
  logic        MemStall;

  modport master (
    output MemRead, MemWrite, MemAddr, MemDataIn, ByteEn,
    input  MemDataOut, MemReady, MemError, MemStall
  );

  modport slave (
    input  MemRead, MemWrite, MemAddr, MemDataIn, ByteEn,
    output MemDataOut, MemReady, MemError, MemStall
  );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port word RAM built from four byte-wide lanes, each with its own
// write enable and a registered read port.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           Clock,
  input  logic                           en,
  input  logic [3:0]                     laneWe,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] laneMem [DEPTH_WORDS];
    logic [7:0] laneRd;

    always_ff @(posedge Clock) begin
      if (en) begin
        if (laneWe[gi]) begin
          laneMem[addr] <= wdata[8*gi +: 8];
        end
        laneRd <= laneMem[addr];
      end
    end

    assign rdata[8*gi +: 8] = laneRd;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one MEM-stage access at a time, inserts
// WAIT_STATES extra cycles, then pulses MemReady (with MemError if rejected).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic                 Clock,
  input logic                 nReset,
  data_mem_responder_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_U   = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  dmem_state_t stateReg, stateNext;
  logic [3:0]  waitCntReg, waitCntNext;

  logic [AW-1:0] addrReg;
  logic [31:0]   dataReg;
  logic [3:0]    beReg;
  logic          writeReg;
  logic          errReg;

  logic          request;
  logic          reqIllegal;
  logic [AW-1:0] accAddr;
  logic [31:0]   accData;
  logic [3:0]    accBe;
  logic          accWrite;
  logic          accErr;
  logic          enterResp;
  logic          ramEn;
  logic [3:0]    ramWe;
  logic [31:0]   ramRdata;

  assign request    = bus.MemRead | bus.MemWrite;
  assign reqIllegal = (bus.MemRead & bus.MemWrite)
                    | ({2'b00, bus.MemAddr[31:2]} >= DEPTH_U)
                    | !be_legal(bus.MemAddr[1:0], bus.ByteEn);

  // State register
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      stateReg   <= IDLE;
      waitCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    case (stateReg)
      IDLE: begin
        if (request) begin
          if (WAIT_STATES > 0) begin
            stateNext   = WAIT;
            waitCntNext = WAIT_INIT;
          end else begin
            stateNext = RESP;
          end
        end
      end
      WAIT: begin
        if (waitCntReg == 4'd0) begin
          stateNext = RESP;
        end else begin
          waitCntNext = waitCntReg - 4'd1;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request snapshot taken at acceptance; later input changes are ignored.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      addrReg  <= '0;
      dataReg  <= '0;
      beReg    <= '0;
      writeReg <= 1'b0;
      errReg   <= 1'b0;
    end else if (stateReg == IDLE && request) begin
      addrReg  <= bus.MemAddr[AW+1:2];
      dataReg  <= bus.MemDataIn;
      beReg    <= bus.ByteEn;
      writeReg <= bus.MemWrite;
      errReg   <= reqIllegal;
    end
  end

  // Output and RAM-control logic. With zero wait states the access enters
  // RESP straight from IDLE, so the live request must steer the RAM then.
  always_comb begin
    accAddr  = addrReg;
    accData  = dataReg;
    accBe    = beReg;
    accWrite = writeReg;
    accErr   = errReg;
    if (stateReg == IDLE) begin
      accAddr  = bus.MemAddr[AW+1:2];
      accData  = bus.MemDataIn;
      accBe    = bus.ByteEn;
      accWrite = bus.MemWrite;
      accErr   = reqIllegal;
    end
    enterResp = nReset && (stateNext == RESP) && (stateReg != RESP);
    ramEn     = enterResp;
    ramWe     = (enterResp && accWrite && !accErr) ? accBe : 4'b0000;

    bus.MemReady   = (stateReg == RESP);
    bus.MemError   = (stateReg == RESP) && errReg;
    bus.MemDataOut = ((stateReg == RESP) && !errReg) ? (ramRdata & be_mask(beReg)) : 32'h0;
    bus.MemStall   = request && (stateReg != RESP) && nReset;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .Clock (Clock),
    .en    (ramEn),
    .laneWe(ramWe),
    .addr  (accAddr),
    .wdata (accData),
    .rdata (ramRdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances with 1, 0, 3 and 15
// wait states share one stimulus bus, selected per access.
module tb_data_mem_responder;

  logic        Clock;
  logic [3:0]  rstN;
  int          sel;
  logic        memRead, memWrite;
  logic [31:0] memAddr, memDataIn;
  logic [3:0]  byteEn;

  logic [31:0] dataV  [4];
  logic        rdyV   [4];
  logic        errV   [4];
  logic        stallV [4];

  int checks;
  int failures;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic int ws(input int idx);
    case (idx)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    data_mem_responder_if bus ();

    assign bus.MemRead   = memRead  && (sel == gi);
    assign bus.MemWrite  = memWrite && (sel == gi);
    assign bus.MemAddr   = memAddr;
    assign bus.MemDataIn = memDataIn;
    assign bus.ByteEn    = byteEn;

    data_mem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_STATES(ws(gi))
    ) dut (
      .Clock (Clock),
      .nReset(rstN[gi]),
      .bus   (bus.slave)
    );

    assign dataV[gi]  = bus.MemDataOut;
    assign rdyV[gi]   = bus.MemReady;
    assign errV[gi]   = bus.MemError;
    assign stallV[gi] = bus.MemStall;
  end

  // One access; lat counts edges from acceptance to the Ready cycle (-1 = timeout).
  // mode 1: corrupt address/data after acceptance; mode 2: drop request after acceptance.
  task automatic access(input int inst, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int mode,
                        output logic [31:0] rdData, output logic err,
                        output int lat, output int stallWait, output logic stallRdy);
    bit done;
    sel = inst; memRead = rd; memWrite = wr;
    memAddr = addr; memDataIn = data; byteEn = be;
    lat = -1; stallWait = 0; stallRdy = 1'b0; rdData = '0; err = 1'b0; done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge Clock);
      if (rdyV[inst]) begin
        lat = n; rdData = dataV[inst]; err = errV[inst]; stallRdy = stallV[inst]; done = 1'b1;
      end else if (n > 0 && stallV[inst]) begin
        stallWait++;
      end
      if (!done && n == 1) begin
        if (mode == 1) begin
          memAddr = memAddr ^ 32'hC; memDataIn = ~memDataIn;
        end else if (mode == 2) begin
          memRead = 1'b0; memWrite = 1'b0;
        end
      end
    end
    @(posedge Clock); #1;
    memRead = 1'b0; memWrite = 1'b0;
    $display("access inst=%0d rd=%0b wr=%0b addr=%h wdata=%h be=%b -> rdata=%h err=%0b lat=%0d",
             inst, rd, wr, addr, data, be, rdData, err, lat);
  endtask

  task automatic test_reset();
    rstN = 4'b0000; sel = 0; memRead = 1'b1; memWrite = 1'b0;
    memAddr = 32'h0; memDataIn = 32'h0; byteEn = 4'b1111;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rdyV[i] !== 1'b0) begin failures++; $display("FAIL reset_ready inst=%0d got=%b exp=0", i, rdyV[i]); end
      checks++; if (errV[i] !== 1'b0) begin failures++; $display("FAIL reset_error inst=%0d got=%b exp=0", i, errV[i]); end
      checks++; if (dataV[i] !== 32'h0) begin failures++; $display("FAIL reset_data inst=%0d got=%h exp=0", i, dataV[i]); end
      checks++; if (stallV[i] !== 1'b0) begin failures++; $display("FAIL reset_stall inst=%0d got=%b exp=0", i, stallV[i]); end
    end
    @(posedge Clock); #1;
    rstN = 4'b1111;
    @(negedge Clock);
    checks++; if (stallV[0] !== 1'b1) begin failures++; $display("FAIL stall_after_reset got=%b exp=1", stallV[0]); end
    memRead = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
  endtask

  task automatic test_word_rw();
    logic [31:0] d; logic e; int lat, sw; logic sr;
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (lat !== 2) begin failures++; $display("FAIL w1_write_latency got=%0d exp=2", lat); end
    checks++; if (sw !== 1) begin failures++; $display("FAIL w1_write_stall_cycles got=%0d exp=1", sw); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL w1_write_error got=%b exp=0", e); end
    checks++; if (sr !== 1'b0) begin failures++; $display("FAIL w1_stall_in_ready got=%b exp=0", sr); end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (lat !== 2) begin failures++; $display("FAIL w1_read_latency got=%0d exp=2", lat); end
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL w1_read_data got=%h exp=deadbeef", d); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL w1_read_error got=%b exp=0", e); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d; logic e; int lat, sw; logic sr;
    access(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'b1111, 0, d, e, lat, sw, sr);
    access(0, 1'b0, 1'b1, 32'h13, 32'hAA000000, 4'b1000, 0, d, e, lat, sw, sr);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL byte_write_error got=%b exp=0", e); end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (d !== 32'hAA223344) begin failures++; $display("FAIL byte_merge_word got=%h exp=aa223344", d); end
    access(0, 1'b1, 1'b0, 32'h12, 32'h0, 4'b1100, 0, d, e, lat, sw, sr);
    checks++; if (d !== 32'hAA220000) begin failures++; $display("FAIL half_hi_read got=%h exp=aa220000", d); end
    access(0, 1'b1, 1'b0, 32'h11, 32'h0, 4'b0010, 0, d, e, lat, sw, sr);
    checks++; if (d !== 32'h00003300) begin failures++; $display("FAIL byte1_read got=%h exp=00003300", d); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL byte1_read_error got=%b exp=0", e); end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic e; int lat, sw; logic sr;
    access(0, 1'b0, 1'b1, 32'h0, 32'h55667788, 4'b1111, 0, d, e, lat, sw, sr);
    access(0, 1'b0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL misaligned_word_error got=%b exp=1", e); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL misaligned_latency got=%0d exp=2", lat); end
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL misaligned_data got=%h exp=0", d); end
    access(0, 1'b1, 1'b1, 32'h0, 32'h01010101, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL rd_and_wr_error got=%b exp=1", e); end
    access(0, 1'b0, 1'b1, 32'h1000, 32'h99999999, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL out_of_range_error got=%b exp=1", e); end
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0110, 0, d, e, lat, sw, sr);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL be0110_error got=%b exp=1", e); end
    access(0, 1'b1, 1'b0, 32'h2, 32'h0, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL illegal_read_data got=%h exp=0", d); end
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (d !== 32'h55667788) begin failures++; $display("FAIL illegal_no_write got=%h exp=55667788", d); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL legal_after_illegal_error got=%b exp=0", e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat, sw; logic sr;
    logic [5:0] hist; logic [31:0] got [2]; logic stallR [2]; int nReady;
    access(1, 1'b0, 1'b1, 32'h0, 32'h0A0A0A0A, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (lat !== 1) begin failures++; $display("FAIL w0_write_latency got=%0d exp=1", lat); end
    access(1, 1'b0, 1'b1, 32'h4, 32'h0B0B0B0B, 4'b1111, 0, d, e, lat, sw, sr);
    sel = 1; memRead = 1'b1; memWrite = 1'b0; memAddr = 32'h0; byteEn = 4'b1111;
    hist = '0; nReady = 0; got[0] = '0; got[1] = '0; stallR[0] = 1'b1; stallR[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock);
      hist[c] = rdyV[1];
      if (rdyV[1] && nReady < 2) begin
        got[nReady] = dataV[1]; stallR[nReady] = stallV[1];
      end
      @(posedge Clock); #1;
      if (hist[c]) begin
        nReady++;
        if (nReady == 1) memAddr = 32'h4;
        else memRead = 1'b0;
      end
    end
    memRead = 1'b0;
    $display("back_to_back inst=1 ready_history=%b data0=%h data1=%h", hist, got[0], got[1]);
    checks++; if (hist !== 6'b001010) begin failures++; $display("FAIL b2b_ready_cycles got=%b exp=001010", hist); end
    checks++; if ((hist & (hist >> 1)) !== 6'b0) begin failures++; $display("FAIL b2b_consecutive_ready got=%b exp=0", hist & (hist >> 1)); end
    checks++; if (got[0] !== 32'h0A0A0A0A) begin failures++; $display("FAIL b2b_data0 got=%h exp=0a0a0a0a", got[0]); end
    checks++; if (got[1] !== 32'h0B0B0B0B) begin failures++; $display("FAIL b2b_data1 got=%h exp=0b0b0b0b", got[1]); end
    checks++; if (stallR[0] !== 1'b0 || stallR[1] !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_ready got=%b%b exp=00", stallR[0], stallR[1]); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d; logic e; int lat, sw; logic sr; int spurious;
    access(2, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (lat !== 4) begin failures++; $display("FAIL w3_write_latency got=%0d exp=4", lat); end
    sel = 2; memWrite = 1'b1; memRead = 1'b0; memAddr = 32'h20; memDataIn = 32'h12345678; byteEn = 4'b1111;
    @(posedge Clock);
    @(posedge Clock); #1;
    rstN[2] = 1'b0;
    @(negedge Clock);
    checks++; if (stallV[2] !== 1'b0) begin failures++; $display("FAIL stall_during_reset got=%b exp=0", stallV[2]); end
    @(posedge Clock); #1;
    rstN[2] = 1'b1; memWrite = 1'b0;
    @(negedge Clock);
    $display("reset_mid_wait inst=2 ready=%b err=%b data=%h", rdyV[2], errV[2], dataV[2]);
    checks++; if (rdyV[2] !== 1'b0 || errV[2] !== 1'b0 || dataV[2] !== 32'h0) begin
      failures++; $display("FAIL abort_outputs got=%b/%b/%h exp=0/0/0", rdyV[2], errV[2], dataV[2]);
    end
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock);
      if (rdyV[2]) spurious++;
    end
    checks++; if (spurious !== 0) begin failures++; $display("FAIL abort_spurious_ready got=%0d exp=0", spurious); end
    @(posedge Clock); #1;
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (d !== 32'hCAFEF00D) begin failures++; $display("FAIL abort_no_commit got=%h exp=cafef00d", d); end
  endtask

  task automatic test_wait_inputs();
    logic [31:0] d; logic e; int lat, sw; logic sr;
    access(2, 1'b0, 1'b1, 32'h28, 32'h28282828, 4'b1111, 0, d, e, lat, sw, sr);
    access(2, 1'b0, 1'b1, 32'h24, 32'h0BADCAFE, 4'b1111, 1, d, e, lat, sw, sr);
    checks++; if (sw !== 3) begin failures++; $display("FAIL w3_stall_cycles got=%0d exp=3", sw); end
    access(2, 1'b1, 1'b0, 32'h24, 32'h0, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (d !== 32'h0BADCAFE) begin failures++; $display("FAIL latched_write_data got=%h exp=0badcafe", d); end
    access(2, 1'b1, 1'b0, 32'h28, 32'h0, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (d !== 32'h28282828) begin failures++; $display("FAIL latched_addr_untouched got=%h exp=28282828", d); end
    access(2, 1'b0, 1'b1, 32'h30, 32'h30303030, 4'b1111, 2, d, e, lat, sw, sr);
    checks++; if (lat !== 4) begin failures++; $display("FAIL dropped_req_ready got=%0d exp=4", lat); end
    access(2, 1'b1, 1'b0, 32'h30, 32'h0, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (d !== 32'h30303030) begin failures++; $display("FAIL dropped_req_commit got=%h exp=30303030", d); end
  endtask

  task automatic test_long_wait();
    logic [31:0] d; logic e; int lat, sw; logic sr;
    access(3, 1'b0, 1'b1, 32'h40, 32'h77778888, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (lat !== 16) begin failures++; $display("FAIL w15_write_latency got=%0d exp=16", lat); end
    checks++; if (sw !== 15) begin failures++; $display("FAIL w15_stall_cycles got=%0d exp=15", sw); end
    access(3, 1'b1, 1'b0, 32'h40, 32'h0, 4'b1111, 0, d, e, lat, sw, sr);
    checks++; if (lat !== 16) begin failures++; $display("FAIL w15_read_latency got=%0d exp=16", lat); end
    checks++; if (d !== 32'h77778888) begin failures++; $display("FAIL w15_read_data got=%h exp=77778888", d); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rstN = 4'b0000; sel = 0; memRead = 1'b0; memWrite = 1'b0;
    memAddr = '0; memDataIn = '0; byteEn = 4'b1111;
    @(posedge Clock); #1;
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_illegal();
    test_back_to_back();
    test_reset_mid_wait();
    test_wait_inputs();
    test_long_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
